// File: rtl/positadd_arbiter.sv
// positadd_arbiter: round-robin front end that shares one pipelined posit
// adder among NREQ requesters. A latency-matched tag pipe carries the
// requester ID alongside each operation. Results land in a first-word-fall-
// through FIFO. A credit counter keeps the FIFO from overflowing, which
// matters because the adder cannot be stalled.
// Optional build macro: POSITADD_ARB_STATS_EN adds the stat_issued and
// stat_stall counter outputs.
//
// state | meaning
// RUN   | grants allowed
// DRAIN | no grants; waiting for in-flight operations to complete
// HALT  | no grants; pipe empty; idle once the FIFO is empty
module positadd_arbiter #(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_in1,
  input  logic [NREQ*32-1:0] req_in2,
  output logic               add_start,
  output logic [31:0]        add_in1,
  output logic [31:0]        add_in2,
  input  logic [31:0]        add_result,
  input  logic               add_inf,
  input  logic               add_zero,
  input  logic               add_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDW-1:0]     out_id,
  output logic [31:0]        out_result,
  output logic               out_inf,
  output logic               out_zero,
  input  logic               flush,
  output logic               idle,
  output logic               err
`ifdef POSITADD_ARB_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = IDW + 34;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [CW-1:0]      credits_q;
  logic               add_start_q;
  logic [31:0]        add_in1_q, add_in2_q;
  logic [LATENCY-1:0] tv_q;
  logic [IDW-1:0]     tid_q [LATENCY];
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               err_q;
  logic               gnt_found, can_issue, issue, pop, push, pipe_busy;
  logic [IDW-1:0]     gnt_id;
  logic [31:0]        sel_in1, sel_in2;
  logic [EW-1:0]      head;

  // Round-robin search from rr_q upward, plus operand select for the winner
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    sel_in1   = '0;
    sel_in2   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!gnt_found && req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_in1 = req_in1[k*32 +: 32];
        sel_in2 = req_in2[k*32 +: 32];
      end
    end
  end

  // rst_n is in the grant qualifier so req_ready drops the moment reset asserts
  assign can_issue = rst_n && (state_q == S_RUN) && (credits_q != '0);
  assign issue     = can_issue && gnt_found;
  assign pop       = out_valid && out_ready;
  assign push      = add_done && tv_q[LATENCY-1] && ((count_q != CRED_MAX) || pop);
  assign pipe_busy = |tv_q;

  // One-hot ready to the granted requester and next round-robin pointer
  always_comb begin
    req_ready = '0;
    rr_d      = rr_q;
    if (issue) begin
      for (int k = 0; k < NREQ; k++) req_ready[k] = (gnt_id == IDW'(k));
      rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Issue register and tag pipe aligned so tv_q[LATENCY-1] coincides with add_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      rr_q        <= '0;
      tv_q        <= '0;
      for (int k = 0; k < LATENCY; k++) tid_q[k] <= '0;
    end else begin
      add_start_q <= issue;
      rr_q        <= rr_d;
      if (issue) begin
        add_in1_q <= sel_in1;
        add_in2_q <= sel_in2;
      end
      tv_q[0]  <= issue;
      tid_q[0] <= gnt_id;
      for (int k = 1; k < LATENCY; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
    end
  end

  // Credits cover both in-flight ops and occupied FIFO entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CRED_MAX;
    end else begin
      case ({issue, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; data only, never read while invalid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tid_q[LATENCY-1], add_result, add_inf, add_zero};
  end

  // Sticky error when the adder's done strobe disagrees with the tag pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_q <= 1'b0;
    else if (add_done != tv_q[LATENCY-1]) err_q <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next-state and idle decode
  always_comb begin
    state_d = state_q;
    idle    = 1'b0;
    case (state_q)
      S_RUN:   if (flush) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!flush)                         state_d = S_RUN;
        else if (!pipe_busy && !add_start_q) state_d = S_HALT;
      end
      S_HALT: begin
        idle = (count_q == '0);
        if (!flush) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_id     = out_valid ? head[EW-1 -: IDW] : '0;
  assign out_result = out_valid ? head[33:2] : '0;
  assign out_inf    = out_valid & head[1];
  assign out_zero   = out_valid & head[0];
  assign add_start  = add_start_q;
  assign add_in1    = add_in1_q;
  assign add_in2    = add_in2_q;
  assign err        = err_q;

`ifdef POSITADD_ARB_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  // Issue count and cycles lost to exhausted credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (issue) stat_issued_q <= stat_issued_q + 32'd1;
      if ((|req_valid) && (state_q == S_RUN) && (credits_q == '0))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: doc/positadd_arbiter.md
Name: positadd_arbiter

Overview:
- Shares one pipelined posit adder (32-bit, ES=2, fixed latency, no backpressure) among NREQ requesters.
- Round-robin arbitration; at most one operand pair issued per cycle.
- Tracks the requester ID of each in-flight operation in a tag pipe matched to adder latency; results go into an output FIFO with requester ID attached.
- Sits between kernel lanes and the positadd_8 instance; the adder is instantiated beside it and connected through the add_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LATENCY, 8, start-to-done latency of the attached adder, in cycles
- FIFO_DEPTH, 8, output FIFO entries (power of two, >= 2)
- IDW, $clog2(NREQ), requester ID width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_in1  in  NREQ*32  packed operand A; slice i belongs to requester i
- req_in2  in  NREQ*32  packed operand B
- add_start  out  1  issue strobe to adder
- add_in1  out  32  operand A to adder
- add_in2  out  32  operand B to adder
- add_result  in  32  adder result
- add_inf  in  1  adder NaR flag
- add_zero  in  1  adder zero flag
- add_done  in  1  adder result valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accept
- out_id  out  IDW  requester ID of head entry
- out_result  out  32  head result
- out_inf  out  1  head NaR flag
- out_zero  out  1  head zero flag
- flush  in  1  stop issuing and drain (level)
- idle  out  1  nothing in flight, FIFO empty, state HALT
- err  out  1  sticky: add_done disagreed with tag pipe

Behaviour:
- Reset (async assert, sync release):
  - state RUN, rr pointer 0, tag pipe cleared, FIFO empty, credits = FIFO_DEPTH.
  - All outputs 0: req_ready, add_start, add_in1/2, out_*, idle, err.
- Credits:
  - Issue is permitted only if credits > 0.
  - Credits decrement on issue and increment on a FIFO pop (out_valid & out_ready).
  - Issue and pop in the same cycle leave credits unchanged.
  - The FIFO therefore never overflows even though the adder cannot stall.
- Arbitration (combinational grant, registered issue):
  - Grant goes to the first requester with req_valid set, searching from rr pointer upward and wrapping at NREQ.
  - req_ready[g] = 1 only if state == RUN and credits > 0.
  - Handshake is req_valid & req_ready.
  - On issue, rr pointer becomes g+1 mod NREQ; otherwise it holds.
  - The next edge registers add_start=1, add_in1/add_in2 = operands of g, and tag {1, g} into tag pipe stage 0.
  - With no issue, add_start=0 and operand registers hold their values.
- Tag pipe: LATENCY-1 further register stages after the issue register, so the tag valid bit lines up with add_done.
- Completion and FIFO:
  - On add_done, write {tag id, add_result, add_inf, add_zero} into the FIFO.
  - If add_done != aligned tag valid, set err; err clears only on reset.
  - FIFO is first-word-fall-through.
  - A same-cycle push and pop is allowed in every state, including when the FIFO is full and popping.
- States:
  - RUN: grants allowed. flush=1 moves to DRAIN.
  - DRAIN: no grants. Move to HALT when the tag pipe is empty and add_start=0.
  - HALT: no grants; idle = FIFO empty. flush=0 returns to RUN.
  - flush released during DRAIN returns to RUN.
- Reset mid-operation discards in-flight tags. Adder results arriving after reset release are not pushed (tag invalid) and set err. Integration must reset the adder's input registers together with this block.
- Throughput: one issue per cycle sustained while credits last. Latency from req handshake to out_valid is LATENCY+1 cycles with an empty FIFO.

Optional Feature:
- Macro: POSITADD_ARB_STATS_EN.
- Defined:
  - Adds output stat_issued (32 bits), counting issues, wrapping modulo 2^32.
  - Adds output stat_stall (32 bits), counting cycles where some req_valid was set but no grant was given because credits == 0.
  - Both reset to 0.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
- Single op: requester 2 sends 0x40000000 + 0x40000000, out_ready=1 -> out_valid 9 cycles after the handshake, out_id=2, out_result=0x48000000, inf=0, zero=0.
- Cancellation: 0x40000000 + 0xC0000000 -> out_result=0x00000000, out_zero=1.
- Round-robin fairness: all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; out_id sequence matches.
- Backpressure: out_ready=0 with 12 back-to-back requests -> exactly 8 issues, then req_ready=0. Raising out_ready resumes issuing one per pop, with no loss and in order.
- Flush: assert flush with 5 ops in flight -> no further req_ready; idle rises one cycle after the last of the 5 results is popped. Deasserting flush reenables grants.
- Error/reset: force add_done with an empty tag pipe -> err=1 held. Assert rst_n low mid-stream -> all outputs 0 immediately, credits restored to 8.
